// File: rtl/inst_mem_pkg.sv
// Shared definitions for the program-memory loader: FSM encoding, NOP word, default address width.
package inst_mem_pkg;

  localparam int ADDR_W_DEFAULT = 6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_LOAD = S_LOAD,
    ST_HOLD = S_HOLD,
    ST_RUN  = S_RUN
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/inst_mem_loader_ram.sv
// Byte-wide program store: one synchronous write port and four asynchronous read ports,
// packed so read port 0 lands in the most significant byte of rdata_o.
module byte_ram_4r1w
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [7:0]            wdata_i,
  input  logic [4*ADDR_W-1:0]   raddr_i,
  output logic [31:0]           rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Contents are deliberately never cleared; a reload simply overwrites them.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd
      assign rdata_o[8*(3-gi) +: 8] = mem_q[raddr_i[gi*ADDR_W +: ADDR_W]];
    end
  endgenerate

endmodule

// File: rtl/inst_mem_loader.sv
// Program loader in front of the core: streams host bytes into memory while holding the core
// in reset, waits a few cycles, then releases it and serves big-endian 32-bit words.
module inst_mem_loader
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int DEPTH    = 2 ** ADDR_W,
  parameter int RST_HOLD = 2
) (
  input  logic              clk,
  input  logic              rst_master_n,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count,
  output logic              cpu_rst,
  input  logic [ADDR_W-1:0] add_i,
  output logic [31:0]       inst
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int HOLD_W = 4;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEPTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic               wr_en;
  logic [4*ADDR_W-1:0] rd_addr;
  logic [31:0]        rd_word;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    wr_en   = 1'b0;
    // A restart pre-empts everything, including a byte offered in the same cycle.
    if (ld_start) begin
      state_d = ST_LOAD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (ld_valid) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              state_d = ST_HOLD;
              hold_d  = HOLD_LOAD;
            end
          end
        end
        ST_HOLD: begin
          if (hold_q == '0) begin
            state_d = ST_RUN;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        default: ;
      endcase
    end
    ready_d   = (state_d == ST_LOAD);
    done_d    = (state_d == ST_HOLD) || (state_d == ST_RUN);
    cpu_rst_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_master_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_addr
      assign rd_addr[gi*ADDR_W +: ADDR_W] = add_i + ADDR_W'(gi);
    end
  endgenerate

  byte_ram_4r1w #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en && rst_master_n),
    .waddr_i (cnt_q[ADDR_W-1:0]),
    .wdata_i (ld_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_word)
  );

  assign ld_ready = ready_q;
  assign ld_done  = done_q;
  assign ld_count = cnt_q;
  assign cpu_rst  = cpu_rst_q;
  assign inst     = (state_q == ST_RUN) ? rd_word : NOP_INST;

endmodule
